// File: rtl/hazard_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_pipe_ctrl
//   Pipeline-register chain for the X, M and W stages of the 5-stage core,
//   together with the hazard control that forwarding alone cannot resolve:
//     - load-use: the instruction in D reads a register that the load in X
//       writes. F and D are held for one cycle and a bubble is put into X.
//     - taken branch/jump resolved in X: D is flushed and a bubble is put
//       into X.
//   M and W always advance; they never stall and never flush.
//
// Parameters
//   AWIDTH     instruction/datapath width
//   NOP        bubble encoding (addi x0,x0,0)
//
// Ports
//   clk        core clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   Instr_D    instruction in decode
//   RegWEnD    decode-stage register-write enable
//   MemRdD     decode-stage instruction is a load
//   BrTaken_X  branch/jump in X resolved taken this cycle
//   Instr_X/M/W   registered stage instructions (to the forwarding unit)
//   RegWEnX/M/W   registered stage write enables
//   MemRdX     registered execute-stage load flag
//   StallF     hold PC (combinational)
//   StallD     hold F/D register (combinational)
//   FlushD     replace F/D contents with NOP (combinational)
//   StallCnt   cycles with StallF=1      (only with PERF_CNT_EN)
//   FlushCnt   cycles with FlushD=1      (only with PERF_CNT_EN)
//
// Build option
//   PERF_CNT_EN   when defined, adds the StallCnt/FlushCnt outputs and the
//                 counter registers behind them. Both counters wrap silently
//                 and clear on rst. With the macro undefined the counters
//                 do not exist and all other behaviour is unchanged.
// -----------------------------------------------------------------------------
module hazard_pipe_ctrl #(
  parameter int unsigned      AWIDTH = 32,
  parameter logic [AWIDTH-1:0] NOP   = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] Instr_D,
  input  logic              RegWEnD,
  input  logic              MemRdD,
  input  logic              BrTaken_X,
  output logic [AWIDTH-1:0] Instr_X,
  output logic [AWIDTH-1:0] Instr_M,
  output logic [AWIDTH-1:0] Instr_W,
  output logic              RegWEnX,
  output logic              RegWEnM,
  output logic              RegWEnW,
  output logic              MemRdX,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
`endif
);

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic [AWIDTH-1:0] instr_x_q, instr_x_d;
  logic [AWIDTH-1:0] instr_m_q;
  logic [AWIDTH-1:0] instr_w_q;
  logic              regwen_x_q, regwen_x_d;
  logic              regwen_m_q;
  logic              regwen_w_q;
  logic              memrd_x_q, memrd_x_d;

  // Register fields of interest
  logic [4:0] rd_x;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;

  logic luse;
  logic bubble_x;

  assign rd_x  = instr_x_q[11:7];
  assign rs1_d = Instr_D[19:15];
  assign rs2_d = Instr_D[24:20];

  // Both source fields are compared regardless of opcode; U/J types may
  // therefore stall needlessly, which is harmless. A load targeting x0
  // never creates a dependency.
  assign luse = memrd_x_q & regwen_x_q & (rd_x != 5'd0) &
                ((rd_x == rs1_d) | (rd_x == rs2_d));

  // ---------------------------------------------------------------------------
  // Hazard outputs: combinational from current X registers and D inputs.
  // A taken branch discards the instruction in D, so a pending load-use
  // stall on that instruction is meaningless and the branch wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    FlushD   = 1'b0;
    bubble_x = 1'b0;
    if (BrTaken_X) begin
      FlushD   = 1'b1;
      bubble_x = 1'b1;
    end else if (luse) begin
      StallF   = 1'b1;
      StallD   = 1'b1;
      bubble_x = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // X-stage next value: bubble on either hazard, otherwise take D.
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_x_d  = Instr_D;
    regwen_x_d = RegWEnD;
    memrd_x_d  = MemRdD;
    if (bubble_x) begin
      instr_x_d  = NOP;
      regwen_x_d = 1'b0;
      memrd_x_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_x_q  <= NOP;
      instr_m_q  <= NOP;
      instr_w_q  <= NOP;
      regwen_x_q <= 1'b0;
      regwen_m_q <= 1'b0;
      regwen_w_q <= 1'b0;
      memrd_x_q  <= 1'b0;
    end else begin
      instr_x_q  <= instr_x_d;
      instr_m_q  <= instr_x_q;
      instr_w_q  <= instr_m_q;
      regwen_x_q <= regwen_x_d;
      regwen_m_q <= regwen_x_q;
      regwen_w_q <= regwen_m_q;
      memrd_x_q  <= memrd_x_d;
    end
  end

  assign Instr_X = instr_x_q;
  assign Instr_M = instr_m_q;
  assign Instr_W = instr_w_q;
  assign RegWEnX = regwen_x_q;
  assign RegWEnM = regwen_m_q;
  assign RegWEnW = regwen_w_q;
  assign MemRdX  = memrd_x_q;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Plain 32-bit adds; wrap from all-ones to zero is intended.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (FlushD) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
module tb_hazard_pipe_ctrl;

  localparam logic [31:0] NOP_I   = 32'h00000013;
  localparam logic [31:0] ADDI_X1 = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADD_X2  = 32'h00108133; // add  x2,x1,x1
  localparam logic [31:0] LW_X5   = 32'h00002283; // lw   x5,0(x0)
  localparam logic [31:0] ADD_X6  = 32'h00028333; // add  x6,x5,x0
  localparam logic [31:0] LW_X0   = 32'h00002003; // lw   x0,0(x0)
  localparam logic [31:0] ADD_X6Z = 32'h00000333; // add  x6,x0,x0

  logic        clk;
  logic        rst;
  logic [31:0] Instr_D;
  logic        RegWEnD, MemRdD, BrTaken_X;
  logic [31:0] Instr_X, Instr_M, Instr_W;
  logic        RegWEnX, RegWEnM, RegWEnW, MemRdX;
  logic        StallF, StallD, FlushD;
`ifdef PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  hazard_pipe_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .Instr_D   (Instr_D),
    .RegWEnD   (RegWEnD),
    .MemRdD    (MemRdD),
    .BrTaken_X (BrTaken_X),
    .Instr_X   (Instr_X),
    .Instr_M   (Instr_M),
    .Instr_W   (Instr_W),
    .RegWEnX   (RegWEnX),
    .RegWEnM   (RegWEnM),
    .RegWEnW   (RegWEnW),
    .MemRdX    (MemRdX),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD)
`ifdef PERF_CNT_EN
    ,
    .StallCnt  (StallCnt),
    .FlushCnt  (FlushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an in-flight instruction record per stage, index 0=X,1=M,2=W.
  typedef struct {
    logic [31:0] instr;
    bit          wen;
    bit          ld;
  } slot_t;

  slot_t  pipe[3];
  longint m_stalls;
  longint m_flushes;

  function automatic slot_t bubble_slot();
    slot_t s;
    s.instr = NOP_I; s.wen = 0; s.ld = 0;
    return s;
  endfunction

  // Does the instruction in D read the register the load in X writes?
  function automatic bit load_use(input slot_t x, input logic [31:0] d);
    int dst, src1, src2;
    dst  = int'(x.instr[11:7]);
    src1 = int'(d[19:15]);
    src2 = int'(d[24:20]);
    return x.ld && x.wen && dst != 0 && (dst == src1 || dst == src2);
  endfunction

  // One cycle: drive D inputs, check everything mid-cycle, advance the model.
  task automatic step(input logic [31:0] ins, input bit wen, input bit ld,
                      input bit br, input bit r);
    bit    hz;
    bit    e_stall, e_flush;
    slot_t nd;
    Instr_D = ins; RegWEnD = wen; MemRdD = ld; BrTaken_X = br; rst = r;
    @(negedge clk);
    hz      = load_use(pipe[0], ins);
    e_flush = br;
    e_stall = hz && !br;
    check_val("StallF",  {31'd0, StallF},  {31'd0, e_stall});
    check_val("StallD",  {31'd0, StallD},  {31'd0, e_stall});
    check_val("FlushD",  {31'd0, FlushD},  {31'd0, e_flush});
    check_val("Instr_X", Instr_X, pipe[0].instr);
    check_val("Instr_M", Instr_M, pipe[1].instr);
    check_val("Instr_W", Instr_W, pipe[2].instr);
    check_val("RegWEnX", {31'd0, RegWEnX}, {31'd0, pipe[0].wen});
    check_val("RegWEnM", {31'd0, RegWEnM}, {31'd0, pipe[1].wen});
    check_val("RegWEnW", {31'd0, RegWEnW}, {31'd0, pipe[2].wen});
    check_val("MemRdX",  {31'd0, MemRdX},  {31'd0, pipe[0].ld});
`ifdef PERF_CNT_EN
    check_val("StallCnt", StallCnt, m_stalls[31:0]);
    check_val("FlushCnt", FlushCnt, m_flushes[31:0]);
`endif
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) pipe[i] = bubble_slot();
      m_stalls = 0; m_flushes = 0;
    end else begin
      if (e_stall || e_flush) nd = bubble_slot();
      else begin nd.instr = ins; nd.wen = wen; nd.ld = ld; end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nd;
      if (e_stall) m_stalls++;
      if (e_flush) m_flushes++;
    end
    #1;
  endtask

  initial begin
    logic [31:0] ri;
    for (int i = 0; i < 3; i++) begin
      pipe[i].instr = 32'hDEAD_BEEF; pipe[i].wen = 1; pipe[i].ld = 1;
    end
    m_stalls = 0; m_flushes = 0;
    Instr_D = NOP_I; RegWEnD = 0; MemRdD = 0; BrTaken_X = 0; rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) pipe[i] = bubble_slot();

    // 1: reset held for two cycles
    step(NOP_I, 0, 0, 0, 1);
    step(NOP_I, 0, 0, 0, 1);
    check_val("rst_X", Instr_X, NOP_I);
    check_val("rst_W", Instr_W, NOP_I);

    // 2: ALU dependency resolved by forwarding, no stall
    step(ADDI_X1, 1, 0, 0, 0);
    step(ADD_X2,  1, 0, 0, 0);
    check_val("alu_rdM",  {27'd0, Instr_M[11:7]}, 32'd1);
    check_val("alu_wenM", {31'd0, RegWEnM}, 32'd1);
    step(NOP_I, 0, 0, 0, 0);
    step(NOP_I, 0, 0, 0, 0);

    // 3: load-use, exactly one stall cycle, add reaches X one cycle late
    step(LW_X5,  1, 1, 0, 0);
    check_val("lu_pre_stall", {31'd0, StallF}, 32'd0);
    step(ADD_X6, 1, 0, 0, 0);
    check_val("lu_bubble_X", Instr_X, NOP_I);
    check_val("lu_load_M",   Instr_M, LW_X5);
    step(ADD_X6, 1, 0, 0, 0);
    check_val("lu_late_X", Instr_X, ADD_X6);
    step(NOP_I, 0, 0, 0, 0);

    // 4: load to x0 never creates a hazard
    step(LW_X0,   1, 1, 0, 0);
    step(ADD_X6Z, 1, 0, 0, 0);
    check_val("x0_X", Instr_X, ADD_X6Z);
    step(NOP_I, 0, 0, 0, 0);

    // 5: branch taken while load-use pending: branch wins
    step(LW_X5,  1, 1, 0, 0);
    step(ADD_X6, 1, 0, 1, 0);
    check_val("br_bubble_X", Instr_X, NOP_I);
    step(NOP_I, 0, 0, 0, 0);

    // 6: reset during a load-use stall cycle
    step(LW_X5,  1, 1, 0, 0);
    step(ADD_X6, 1, 0, 0, 1);
    check_val("rst_mid_X",   Instr_X, NOP_I);
    check_val("rst_mid_M",   Instr_M, NOP_I);
    check_val("rst_mid_stl", {31'd0, StallF}, 32'd0);
`ifdef PERF_CNT_EN
    check_val("rst_mid_cnt", StallCnt, 32'd0);
`endif

    // Randomized traffic with narrow register fields to provoke hazards
    for (int n = 0; n < 800; n++) begin
      ri = $urandom;
      ri[11:7]  = 5'($urandom_range(0, 3));
      ri[19:15] = 5'($urandom_range(0, 3));
      ri[24:20] = 5'($urandom_range(0, 3));
      step(ri, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
